noc_output_port: RTL
====================

Name: noc_output_port

Overview:
Output-side endpoint of the router crossbar. It accepts flits steered to it by the route logic (port_enable plus a 3-bit port_select over the five input buffers) and stages them in a small FIFO. It transmits them downstream under credit-based flow control. It also generates the port_full and one-hot turn signals that the route logic uses to decide whether this port may be targeted this cycle.

Parameters:
- CREDITS, 4, downstream input-buffer depth; initial and maximum credit count.
- STAGE_DEPTH, 2, staging FIFO depth in flits (power of two, >=2).

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- N_data_i  in  8  flit from north input buffer (bits [7:4] X dest, [3:0] Y dest).
- S_data_i  in  8  flit from south input buffer.
- E_data_i  in  8  flit from east input buffer.
- W_data_i  in  8  flit from west input buffer.
- L_data_i  in  8  flit from local input buffer.
- port_enable  in  1  write strobe from route logic.
- port_select  in  3  source select: 000 N, 001 S, 010 E, 011 W, 100 L.
- credit_i  in  1  one-cycle pulse; downstream freed one slot.
- data_o  out  8  flit to downstream link.
- valid_o  out  1  data_o valid; high for exactly one cycle per flit.
- port_full  out  1  staging FIFO full; route logic must not enable.
- turn  out  5  one-hot arbitration turn: bit4 N, bit3 S, bit2 E, bit1 W, bit0 L.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values (while rst is high):
  - data_o=0, valid_o=0, err_o=0.
  - FIFO empty, so port_full=0.
  - credit_cnt=CREDITS.
  - turn=5'b10000.
  - rst has priority over every other event, including mid-transfer; staged flits are discarded.
- Turn generator:
  - Each cycle, turn rotates right by one: 10000 -> 01000 -> 00100 -> 00010 -> 00001 -> 10000.
  - It rotates unconditionally, independent of enable, full and credits.
  - turn is registered and always one-hot.
- Write path:
  - On an edge with port_enable=1, the flit chosen by port_select is pushed.
  - Select 101/110/111: no push, err_o set.
  - Write while port_full=1: flit dropped, FIFO unchanged, err_o set.
- port_full is combinational from the occupancy register: port_full = (count==STAGE_DEPTH).
  - A pop on the same edge does not make room for a write.
- Transmit path:
  - On each edge where the FIFO is non-empty (pre-edge state) and credit_cnt>0:
    - pop the head into data_o;
    - valid_o<=1;
    - decrement credit_cnt.
  - Otherwise valid_o<=0 and data_o holds its last value.
- Latency: a flit sampled at edge k into an empty FIFO with credits>0 is popped at edge k+1. valid_o is high in the cycle after edge k+1 (2 clocks from enable to valid_o).
- Throughput: one flit per cycle sustained, given credits.
- Credits:
  - credit_cnt has width $clog2(CREDITS+1).
  - Pop and credit_i on the same edge: net unchanged.
  - credit_i alone: +1.
  - credit_i with credit_cnt==CREDITS and no pop: saturate at CREDITS, err_o set.
  - credit_cnt==0: FIFO contents held, no pop, valid_o=0.
- FIFO:
  - Circular read/write pointers with wrap modulo STAGE_DEPTH.
  - Occupancy count goes 0..STAGE_DEPTH.
  - Simultaneous push and pop: count unchanged, order preserved (strict FIFO).
- err_o is cleared only by rst.

Test Plan:
1. Reset: hold rst 2 cycles -> valid_o=0, data_o=0, port_full=0, turn=10000, err_o=0, credit_cnt=4.
2. Single flit: port_enable=1, port_select=010, E_data_i=8'h21 at edge k -> valid_o=1, data_o=8'h21 in the cycle after edge k+1 only; credit_cnt=3.
3. Credit exhaustion: CREDITS=4, no credit_i, one enable per cycle while port_full=0 with flits 8'h01..8'h06:
   - 8'h01..8'h04 transmitted in order;
   - 8'h05, 8'h06 held, port_full=1;
   - one credit_i pulse -> 8'h05 emitted next edge, port_full drops.
4. Overflow: force enable with port_full=1 (FIFO holds 8'h05, 8'h06), W_data_i=8'h77 -> 8'h77 never appears on data_o, err_o=1; same result for port_select=101 with port_full=0.
5. Turn: free-run 6 cycles after reset -> turn sequence 10000, 01000, 00100, 00010, 00001, 10000.
6. Credit saturation and mid-op reset:
   - credit_i with credit_cnt=4 -> stays 4, err_o=1.
   - Then rst with 2 flits staged -> FIFO empty, valid_o=0 the following cycle, err_o=0, turn=10000.

Source files
------------

// File: rtl/noc_output_port.sv
`default_nettype none
// ============================================================================
//  Module   : noc_output_port
//  Purpose  : Output-side endpoint of a NoC router crossbar. Flits steered
//             to this port by the route logic are staged in a small circular
//             FIFO. They are then sent downstream under credit-based flow
//             control. The block also produces the port_full and one-hot turn
//             hints that the route logic consumes.
//  Ports    :
//    clk, rst              rising-edge clock, synchronous active-high reset
//    N/S/E/W/L_data_i[7:0] candidate flits from the five input buffers
//    port_enable           write strobe from the route logic
//    port_select[2:0]      source select (000 N, 001 S, 010 E, 011 W, 100 L)
//    credit_i              one-cycle pulse, downstream freed one slot
//    data_o[7:0]           flit to the downstream link
//    valid_o               data_o valid, one cycle per flit
//    port_full             staging FIFO full (combinational from occupancy)
//    turn[4:0]             one-hot arbitration turn, rotates every cycle
//    err_o                 sticky protocol-error flag, cleared only by rst
//  Revision : 1.0  initial release
// ============================================================================
module noc_output_port #(
  parameter int CREDITS     = 4,
  parameter int STAGE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] N_data_i,
  input  logic [7:0] S_data_i,
  input  logic [7:0] E_data_i,
  input  logic [7:0] W_data_i,
  input  logic [7:0] L_data_i,
  input  logic       port_enable,
  input  logic [2:0] port_select,
  input  logic       credit_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       port_full,
  output logic [4:0] turn,
  output logic       err_o
);

  localparam int PTR_W = $clog2(STAGE_DEPTH);
  localparam int CNT_W = $clog2(STAGE_DEPTH + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] c_full_count  = CNT_W'(STAGE_DEPTH);
  localparam logic [CRD_W-1:0] c_credit_max  = CRD_W'(CREDITS);
  localparam logic [4:0]       c_turn_reset  = 5'b10000;

  // Staging FIFO storage and bookkeeping
  logic [7:0]       r_mem [STAGE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CRD_W-1:0] r_credit_cnt;

  logic [7:0]       w_sel_data;
  logic             w_sel_valid;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;
  logic [CRD_W-1:0] w_credit_next;
  logic             w_credit_overflow;
  logic             w_write_error;

  // Full is judged on the pre-edge occupancy only: a pop on the same edge
  // never frees room for a write.
  assign port_full = (r_count == c_full_count);

  // Source multiplexer; unused select codes are flagged as an error.
  always_comb begin
    w_sel_data  = 8'h00;
    w_sel_valid = 1'b1;
    case (port_select)
      3'b000:  w_sel_data = N_data_i;
      3'b001:  w_sel_data = S_data_i;
      3'b010:  w_sel_data = E_data_i;
      3'b011:  w_sel_data = W_data_i;
      3'b100:  w_sel_data = L_data_i;
      default: w_sel_valid = 1'b0;
    endcase
  end

  assign w_push        = port_enable && w_sel_valid && !port_full;
  assign w_write_error = port_enable && (!w_sel_valid || port_full);
  assign w_pop         = (r_count != '0) && (r_credit_cnt != '0);

  // Occupancy update
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Credit update: a pop consumes one, a returned credit adds one, both
  // together cancel. A return with no room to hold it saturates and errors.
  always_comb begin
    w_credit_next     = r_credit_cnt;
    w_credit_overflow = 1'b0;
    case ({w_pop, credit_i})
      2'b10: w_credit_next = r_credit_cnt - 1'b1;
      2'b01: begin
        if (r_credit_cnt == c_credit_max) begin
          w_credit_overflow = 1'b1;
        end else begin
          w_credit_next = r_credit_cnt + 1'b1;
        end
      end
      default: w_credit_next = r_credit_cnt;
    endcase
  end

  // Storage array is not reset; only the pointers and count define content.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_credit_cnt <= c_credit_max;
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      turn         <= c_turn_reset;
      err_o        <= 1'b0;
    end else begin
      // Pointers wrap naturally since STAGE_DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        data_o   <= r_mem[r_rd_ptr];
      end
      valid_o      <= w_pop;
      r_count      <= w_count_next;
      r_credit_cnt <= w_credit_next;
      turn         <= {turn[0], turn[4:1]};
      if (w_write_error || w_credit_overflow) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
